// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: byte/half/word loads and stores over a
// ready/rvalid handshake, with misalignment detection and transaction timeout.
module mem_access_unit #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [2:0]        i_funct3,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic              o_stall,
  output logic              o_done,
  output logic [31:0]       o_load_data,
  output logic              o_misaligned,
  output logic              o_bus_err,
  output logic [ADDR_W-1:0] o_dmem_addr,
  output logic [31:0]       o_dmem_wdata,
  output logic [3:0]        o_dmem_mask,
  output logic              o_dmem_ren,
  output logic              o_dmem_wen,
  input  logic              i_dmem_ready,
  input  logic              i_dmem_rvalid,
  input  logic [31:0]       i_dmem_rdata
);

  localparam int unsigned CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        mask_q, mask_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              store_q, store_d;
  logic [31:0]       load_data_q, load_data_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic        is_op, aligned, launch, timeout_hit, bus_err;
  logic [3:0]  mask_n;
  logic [31:0] wdata_n, load_ext;

  // Request decode from the incoming instruction
  always_comb begin
    is_op   = i_valid & (i_mem_read | i_mem_write);
    aligned = 1'b1;
    mask_n  = 4'b1111;
    wdata_n = i_wdata;
    case (i_funct3[1:0])
      2'b00: begin
        mask_n  = 4'b0001 << i_addr[1:0];
        wdata_n = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        aligned = ~i_addr[0];
        mask_n  = i_addr[1] ? 4'b1100 : 4'b0011;
        wdata_n = {2{i_wdata[15:0]}};
      end
      default: aligned = (i_addr[1:0] == 2'b00);
    endcase
    launch = (state_q == IDLE) & is_op & aligned;
  end

  // Lane extraction and extension of returned read data
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b = i_dmem_rdata[8*addr_q[1:0] +: 8];
    h = addr_q[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_ext = {{24{b[7]}}, b};
      3'b001:  load_ext = {{16{h[15]}}, h};
      3'b100:  load_ext = {24'd0, b};
      3'b101:  load_ext = {16'd0, h};
      default: load_ext = i_dmem_rdata;
    endcase
  end

  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mask_d      = mask_q;
    funct3_d    = funct3_q;
    store_d     = store_q;
    load_data_d = load_data_q;
    cnt_d       = cnt_q;
    bus_err     = 1'b0;
    case (state_q)
      IDLE: begin
        if (launch) begin
          addr_d   = i_addr;
          wdata_d  = wdata_n;
          mask_d   = mask_n;
          funct3_d = i_funct3;
          store_d  = i_mem_write;
          cnt_d    = '0;
          state_d  = REQ;
        end
      end
      REQ: begin
        cnt_d = cnt_q + 1'b1;
        // Completion is evaluated first so it wins over a simultaneous timeout
        if (i_dmem_ready && store_q) begin
          load_data_d = '0;
          state_d     = RESP;
        end else if (i_dmem_ready && i_dmem_rvalid) begin
          load_data_d = load_ext;
          state_d     = RESP;
        end else if (timeout_hit) begin
          bus_err = 1'b1;
          state_d = IDLE;
        end else if (i_dmem_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (i_dmem_rvalid) begin
          load_data_d = load_ext;
          state_d     = RESP;
        end else if (timeout_hit) begin
          bus_err = 1'b1;
          state_d = IDLE;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      mask_q      <= '0;
      funct3_q    <= '0;
      store_q     <= 1'b0;
      load_data_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mask_q      <= mask_d;
      funct3_q    <= funct3_d;
      store_q     <= store_d;
      load_data_q <= load_data_d;
      cnt_q       <= cnt_d;
    end
  end

  assign o_stall      = launch | (state_q == REQ) | (state_q == WAIT);
  assign o_done       = (state_q == RESP);
  assign o_load_data  = load_data_q;
  assign o_misaligned = (state_q == IDLE) & is_op & ~aligned;
  assign o_bus_err    = bus_err;
  assign o_dmem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign o_dmem_wdata = wdata_q;
  assign o_dmem_mask  = mask_q;
  assign o_dmem_ren   = (state_q == REQ) & ~store_q;
  assign o_dmem_wen   = (state_q == REQ) & store_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized and directed checks of mem_access_unit against a transaction-level
// model that derives lanes, masks and extended data arithmetically.
module tb_mem_access_unit;

  localparam int unsigned TIMEOUT = 16;

  logic        clk;
  logic        rst;
  logic        i_valid, i_mem_read, i_mem_write;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr, i_wdata;
  logic        o_stall, o_done, o_misaligned, o_bus_err;
  logic [31:0] o_load_data, o_dmem_addr, o_dmem_wdata;
  logic [3:0]  o_dmem_mask;
  logic        o_dmem_ren, o_dmem_wen;
  logic        i_dmem_ready, i_dmem_rvalid;
  logic [31:0] i_dmem_rdata;

  int unsigned tests = 0;
  int unsigned fails = 0;

  mem_access_unit #(.ADDR_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
    .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
    .o_stall(o_stall), .o_done(o_done), .o_load_data(o_load_data),
    .o_misaligned(o_misaligned), .o_bus_err(o_bus_err),
    .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata),
    .o_dmem_mask(o_dmem_mask), .o_dmem_ren(o_dmem_ren), .o_dmem_wen(o_dmem_wen),
    .i_dmem_ready(i_dmem_ready), .i_dmem_rvalid(i_dmem_rvalid),
    .i_dmem_rdata(i_dmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete transaction; ready arrives at REQ cycle rdy_dly, read data
  // rv_dly cycles after ready (0 = same cycle). Cycles counted from first REQ.
  task automatic access(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd,
                        input int unsigned rdy_dly, input int unsigned rv_dly);
    int unsigned size, lane, c_done, last;
    logic [31:0] bytev, halfv, exp_mask, exp_wd, exp_ld;
    bit timed;
    size  = int'(f3[1:0]);
    lane  = int'(addr[1:0]);
    bytev = (rd >> (8 * lane)) & 32'hFF;
    halfv = (rd >> (16 * (lane / 2))) & 32'hFFFF;
    case (size)
      0: begin exp_mask = 32'd1 << lane;             exp_wd = (wd & 32'hFF) * 32'h01010101;   end
      1: begin exp_mask = 32'd3 << (2 * (lane / 2)); exp_wd = (wd & 32'hFFFF) * 32'h00010001; end
      default: begin exp_mask = 32'hF;               exp_wd = wd;                             end
    endcase
    case (f3)
      3'b000:  exp_ld = (bytev >= 128) ? bytev - 256 : bytev;
      3'b001:  exp_ld = (halfv >= 32768) ? halfv - 65536 : halfv;
      3'b100:  exp_ld = bytev;
      3'b101:  exp_ld = halfv;
      default: exp_ld = rd;
    endcase
    c_done = st ? rdy_dly : rdy_dly + rv_dly;
    timed  = (c_done > TIMEOUT - 1);
    last   = timed ? TIMEOUT - 1 : c_done;

    @(negedge clk);
    i_valid = 1'b1; i_mem_write = st; i_mem_read = ~st; i_funct3 = f3;
    i_addr = addr; i_wdata = wd; i_dmem_ready = 1'b0; i_dmem_rvalid = 1'b0;
    #1;
    chk1("launch_stall", o_stall, 1'b1);
    chk1("launch_misal", o_misaligned, 1'b0);
    for (int unsigned c = 0; c <= last; c++) begin
      @(negedge clk);
      i_valid = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0;
      i_dmem_ready  = (c == rdy_dly);
      i_dmem_rvalid = !st && (c == rdy_dly + rv_dly);
      i_dmem_rdata  = i_dmem_rvalid ? rd : $urandom;
      #1;
      chk1("busy_stall", o_stall, 1'b1);
      chk1("busy_done", o_done, 1'b0);
      chk1("busy_buserr", o_bus_err, timed && (c == TIMEOUT - 1));
      chk1("busy_ren", o_dmem_ren, !st && (c <= rdy_dly));
      chk1("busy_wen", o_dmem_wen, st && (c <= rdy_dly));
      if (c <= rdy_dly) begin
        chk32("req_addr", o_dmem_addr, addr & 32'hFFFF_FFFC);
        chk32("req_mask", {28'd0, o_dmem_mask}, exp_mask);
        if (st) chk32("req_wdata", o_dmem_wdata, exp_wd);
      end
    end
    @(negedge clk);
    i_dmem_ready = 1'b0; i_dmem_rvalid = 1'b0;
    #1;
    chk1("end_done", o_done, !timed);
    chk1("end_stall", o_stall, 1'b0);
    chk1("end_ren", o_dmem_ren, 1'b0);
    chk1("end_wen", o_dmem_wen, 1'b0);
    chk1("end_buserr", o_bus_err, 1'b0);
    if (!timed) chk32("load_data", o_load_data, st ? 32'd0 : exp_ld);
  endtask

  task automatic misal(input bit st, input logic [2:0] f3, input logic [31:0] addr);
    @(negedge clk);
    i_valid = 1'b1; i_mem_write = st; i_mem_read = ~st; i_funct3 = f3; i_addr = addr;
    #1;
    chk1("mis_flag", o_misaligned, 1'b1);
    chk1("mis_stall", o_stall, 1'b0);
    chk1("mis_ren", o_dmem_ren, 1'b0);
    @(negedge clk);
    i_valid = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0;
    #1;
    chk1("mis_flag_off", o_misaligned, 1'b0);
    chk1("mis_idle_stall", o_stall, 1'b0);
    chk1("mis_idle_ren", o_dmem_ren, 1'b0);
    chk1("mis_idle_wen", o_dmem_wen, 1'b0);
    chk1("mis_idle_done", o_done, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk32({tag, "_vec"}, {o_stall, o_done, o_misaligned, o_bus_err, o_dmem_ren,
                          o_dmem_wen, o_dmem_mask}, 32'd0);
    chk32({tag, "_addr"}, o_dmem_addr, 32'd0);
    chk32({tag, "_wdata"}, o_dmem_wdata, 32'd0);
    chk32({tag, "_ldata"}, o_load_data, 32'd0);
  endtask

  initial begin
    logic [2:0] ld_f3 [5];
    logic [2:0] f3;
    logic [31:0] a;
    bit st;
    ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    rst = 1'b1; i_valid = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0;
    i_funct3 = '0; i_addr = '0; i_wdata = '0;
    i_dmem_ready = 1'b0; i_dmem_rvalid = 1'b0; i_dmem_rdata = '0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    access(1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0, 0, 0);
    access(1'b1, 3'b000, 32'h203, 32'h000000A5, 32'h0, 0, 0);
    access(1'b1, 3'b001, 32'h202, 32'h00001234, 32'h0, 1, 0);
    access(1'b0, 3'b000, 32'h101, 32'h0, 32'h00008000, 0, 3);
    access(1'b0, 3'b100, 32'h101, 32'h0, 32'h00008000, 0, 3);
    access(1'b0, 3'b001, 32'h102, 32'h0, 32'h80017777, 2, 1);
    access(1'b0, 3'b010, 32'h400, 32'h0, 32'h13579BDF, 0, 0);
    misal(1'b0, 3'b010, 32'h102);
    misal(1'b0, 3'b001, 32'h101);
    misal(1'b1, 3'b010, 32'h201);

    // Timeouts and completions right at the limit
    access(1'b1, 3'b010, 32'h500, 32'h11223344, 32'h0, 100, 0);
    access(1'b0, 3'b010, 32'h504, 32'h0, 32'hCAFEF00D, 100, 0);
    access(1'b0, 3'b010, 32'h508, 32'h0, 32'hCAFEF00D, 5, 20);
    access(1'b1, 3'b010, 32'h50C, 32'h55667788, 32'h0, TIMEOUT - 2, 0);
    access(1'b1, 3'b010, 32'h510, 32'h55667788, 32'h0, TIMEOUT - 1, 0);
    access(1'b0, 3'b101, 32'h512, 32'h0, 32'hBEEF0000, TIMEOUT - 3, 2);

    // Asynchronous reset while WAIT is outstanding
    @(negedge clk);
    i_valid = 1'b1; i_mem_read = 1'b1; i_mem_write = 1'b0; i_funct3 = 3'b010; i_addr = 32'h300;
    @(negedge clk);
    i_valid = 1'b0; i_mem_read = 1'b0; i_dmem_ready = 1'b1;
    @(negedge clk);
    i_dmem_ready = 1'b0;
    #1;
    chk1("wait_stall", o_stall, 1'b1);
    chk1("wait_ren", o_dmem_ren, 1'b0);
    rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    access(1'b0, 3'b010, 32'h304, 32'h0, 32'h0BADC0DE, 1, 1);

    for (int unsigned n = 0; n < 40; n++) begin
      st = ($urandom_range(0, 1) == 1);
      f3 = st ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
      a  = $urandom;
      if (f3[1:0] == 2'b01) a[0] = 1'b0;
      if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
      access(st, f3, a, $urandom, $urandom,
             ($urandom_range(0, 9) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 4),
             $urandom_range(0, 4));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised MEM-stage data-memory access unit for the RV32I pipeline, replacing the single-cycle pass-through memory stage. Handles byte, half and word loads and stores with lane masking, store-data replication and load sign/zero extension. Talks to a variable-latency data memory through a ready/rvalid handshake, stalls the pipeline while an access is outstanding, flags misaligned accesses, and times out hung transactions.

## Interface
Parameters:
- ADDR_W, 32, byte address width.
- TIMEOUT, 16, cycles an access may stay in REQ+WAIT before it is aborted (≥2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  MEM-stage instruction valid.
- i_mem_read  in  1  load instruction.
- i_mem_write  in  1  store instruction; wins if both read and write are high.
- i_funct3  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000/001/010.
- i_addr  in  ADDR_W  effective byte address (ALU result).
- i_wdata  in  32  rs2 store data.
- o_stall  out  1  hold upstream pipeline.
- o_done  out  1  one-cycle completion pulse.
- o_load_data  out  32  extended load result, valid while o_done=1.
- o_misaligned  out  1  misaligned-access pulse; no bus activity.
- o_bus_err  out  1  timeout pulse.
- o_dmem_addr  out  ADDR_W  word-aligned address ({i_addr[ADDR_W-1:2],2'b00}, registered).
- o_dmem_wdata  out  32  lane-replicated store data.
- o_dmem_mask  out  4  active byte lanes.
- o_dmem_ren  out  1  read request.
- o_dmem_wen  out  1  write request.
- i_dmem_ready  in  1  memory accepts request this cycle.
- i_dmem_rvalid  in  1  read data valid.
- i_dmem_rdata  in  32  read data.

## Operation
- States: IDLE, REQ, WAIT, RESP.
- launch = IDLE & i_valid & (i_mem_read | i_mem_write) & aligned.
- Aligned: word needs addr[1:0]=00, half needs addr[0]=0, byte always.
- IDLE: on launch, register addr, wdata, mask, funct3, op → REQ. On misaligned op: o_misaligned=1 combinationally, state stays IDLE, no stall.
- REQ: drive ren (load) or wen (store) with registered addr/mask/wdata. Hold all request outputs stable until i_dmem_ready=1. Store + ready → RESP. Load + ready → WAIT; if i_dmem_rvalid=1 in the same cycle, capture data → RESP directly.
- WAIT: ren/wen low; on i_dmem_rvalid capture extended data → RESP.
- RESP: o_done=1 for one cycle; o_load_data holds captured value (0 for stores) → IDLE. No launch from RESP.
- Store masks: SB 0001<<addr[1:0], data {4{b}}; SH 0011<<(2*addr[1]), data {2{h}}; SW 1111. Load mask uses the same lane rule.
- Load extract: byte lane addr[1:0] or half lane addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- Timeout: counter clears on launch and increments each cycle in REQ/WAIT. When count reaches TIMEOUT-1 with no completion, the access aborts: o_bus_err=1 for one cycle, ren/wen drop, → IDLE, o_done stays low. A completion in the same cycle takes priority over the timeout.
- rvalid arriving outside WAIT/REQ-load is ignored.

## Timing
- Reset (async): state IDLE; counter 0; every output 0, including o_dmem_addr, o_dmem_wdata, o_dmem_mask and o_load_data.
- o_stall = launch | state∈{REQ,WAIT}; it is low in RESP, so the pipeline advances on the o_done cycle.
- Best case, ready and rvalid in the first REQ cycle: launch cycle T, REQ at T+1, RESP/o_done at T+2. Store total: 3 cycles.
- Request outputs are registered and change only on IDLE→REQ entry or on exit from REQ.
- rst asserted mid-access drops ren/wen immediately. No o_done or o_bus_err is generated for the aborted access.

## Test plan
- SW addr 0x104 data 0xDEADBEEF, ready at first REQ cycle → wen=1, mask 1111, addr 0x104, o_done at T+2, stall high T..T+1.
- SB addr 0x203 data 0x000000A5 → mask 1000, wdata 0xA5A5A5A5, addr 0x200. SH addr 0x202 data 0x1234 → mask 1100, wdata 0x12341234.
- LB addr 0x101, rdata 0x00008000 after 3 WAIT cycles → o_load_data 0xFFFFFF80. LBU gives 0x00000080. LH addr 0x102, rdata 0x8001xxxx → 0xFFFF8001.
- LW addr 0x102 and LH addr 0x101 → o_misaligned pulse, no ren, stall 0, state IDLE.
- ready held 0, TIMEOUT=16 → o_bus_err after 16 cycles in REQ, no o_done, ren drops. Repeat with ready on cycle 15 → normal completion, no error.
- Assert rst while in WAIT → all outputs 0 asynchronously. A following LW completes normally.
